// File: rtl/pipelined_calculator.sv
// Register-file calculator: 2**ADDR_W x DATA_W register file, single-cycle
// ALU and an iterative shift-add multiplier behind a valid/ready handshake.
// All results (busY, Carry, Out_valid) are registered.
module pipelined_calculator #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RW,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Sel,
  input  logic [3:0]        Ctrl,
  output logic [DATA_W-1:0] busY,
  output logic              Carry,
  output logic              Out_valid
);

  localparam int SHW  = $clog2(DATA_W);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [SHW-1:0] LAST = SHW'(DATA_W - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_ROL  = 4'd9,
    OP_SLT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_PASS = 4'd12
  } op_e;

  typedef enum logic {IDLE, MUL} state_e;

  state_e state, state_n;

  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   op_a, op_b;
  logic [SHW-1:0]      sh;
  logic                accept, is_mul;

  logic [DATA_W-1:0]   alu_r;
  logic                alu_c;
  logic [DATA_W:0]     sum_w, sll_w, srl_w, sra_w;
  logic [2*DATA_W-1:0] rol_w;

  logic [2*DATA_W-1:0] mcand, acc, acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [SHW-1:0]      cnt;
  logic [ADDR_W-1:0]   m_rw;
  logic                m_wen;
  logic                mul_done;

  // Operand fetch; R0 always reads as zero
  always_comb begin
    op_b   = (RY == '0) ? '0 : regs[RY];
    op_a   = Sel ? DataIn : ((RX == '0) ? '0 : regs[RX]);
    sh     = op_b[SHW-1:0];
    accept = In_valid && In_ready;
    is_mul = (Ctrl == OP_MUL);
  end

  // Single-cycle ALU; the extra bit of each widened shift captures the
  // last bit shifted out, and is naturally 0 when the shift amount is 0
  always_comb begin
    sum_w = '0;
    sll_w = {1'b0, op_a} << sh;
    srl_w = {op_a, 1'b0} >> sh;
    sra_w = (DATA_W + 1)'($signed({op_a, 1'b0}) >>> sh);
    rol_w = {op_a, op_a} << sh;
    alu_r = '0;
    alu_c = 1'b0;
    case (Ctrl)
      OP_ADD: begin
        sum_w = {1'b0, op_a} + {1'b0, op_b};
        alu_r = sum_w[DATA_W-1:0];
        alu_c = sum_w[DATA_W];
      end
      OP_SUB: begin
        alu_r = op_a - op_b;
        alu_c = (op_a < op_b);
      end
      OP_AND:  alu_r = op_a & op_b;
      OP_OR:   alu_r = op_a | op_b;
      OP_XOR:  alu_r = op_a ^ op_b;
      OP_NOT:  alu_r = ~op_a;
      OP_SLL: begin
        alu_r = sll_w[DATA_W-1:0];
        alu_c = sll_w[DATA_W];
      end
      OP_SRL: begin
        alu_r = srl_w[DATA_W:1];
        alu_c = srl_w[0];
      end
      OP_SRA: begin
        alu_r = sra_w[DATA_W:1];
        alu_c = sra_w[0];
      end
      OP_ROL:  alu_r = rol_w[2*DATA_W-1:DATA_W];
      OP_SLT:  alu_r = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_PASS: alu_r = op_a;
      default: begin
        alu_r = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  // One shift-add step; the final step's sum is the product
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    mul_done = (state == MUL) && (cnt == LAST);
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && is_mul) state_n = MUL;
      MUL:     if (cnt == LAST)      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    In_ready = (state == IDLE);
  end

  // Multiplier operand/accumulator registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      m_rw   <= '0;
      m_wen  <= 1'b0;
    end else if (accept && is_mul) begin
      mcand  <= {{DATA_W{1'b0}}, op_a};
      mplier <= op_b;
      acc    <= '0;
      cnt    <= '0;
      m_rw   <= RW;
      m_wen  <= WEN;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Registered result outputs; Out_valid is a one-cycle pulse
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busY      <= '0;
      Carry     <= 1'b0;
      Out_valid <= 1'b0;
    end else begin
      Out_valid <= 1'b0;
      if (accept && !is_mul) begin
        busY      <= alu_r;
        Carry     <= alu_c;
        Out_valid <= 1'b1;
      end else if (mul_done) begin
        busY      <= acc_next[DATA_W-1:0];
        Carry     <= |acc_next[2*DATA_W-1:DATA_W];
        Out_valid <= 1'b1;
      end
    end
  end

  // Register file writeback; R0 is never written
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regs <= '{default: '0};
    end else if (accept && !is_mul && WEN && (RW != '0)) begin
      regs[RW] <= alu_r;
    end else if (mul_done && m_wen && (m_rw != '0)) begin
      regs[m_rw] <= acc_next[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipelined_calculator.sv
// Self-checking bench for pipelined_calculator: directed scenarios plus
// randomized instructions checked against an arithmetic reference model.
module tb_pipelined_calculator;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int MASK = (1 << DW) - 1;

  logic          Clk, Rst_n, In_valid, In_ready, WEN, Sel, Carry, Out_valid;
  logic [AW-1:0] RW, RX, RY;
  logic [DW-1:0] DataIn, busY;
  logic [3:0]    Ctrl;

  int n_vec = 0;
  int n_err = 0;
  int mregs [1 << AW];

  pipelined_calculator #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn), .Sel(Sel),
    .Ctrl(Ctrl), .busY(busY), .Carry(Carry), .Out_valid(Out_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int rd(input int idx);
    return (idx == 0) ? 0 : mregs[idx];
  endfunction

  // Reference semantics computed with plain integer arithmetic
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c);
    int sh;
    int sa;
    sh = b % DW;
    sa = (a >= (1 << (DW - 1))) ? a - (1 << DW) : a;
    r = 0;
    c = 0;
    case (op)
      0:  begin r = a + b; c = (r > MASK) ? 1 : 0; end
      1:  begin r = a - b; c = (a < b) ? 1 : 0; end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  begin r = a * (1 << sh); c = (sh == 0) ? 0 : (a >> (DW - sh)) & 1; end
      7:  begin r = a / (1 << sh); c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      8:  begin r = sa >>> sh;     c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      9:  r = (a << sh) | (a >> (DW - sh));
      10: r = (sa < ((b >= (1 << (DW - 1))) ? b - (1 << DW) : b)) ? 1 : 0;
      11: begin r = a * b; c = (r > MASK) ? 1 : 0; end
      12: r = a;
      default: r = 0;
    endcase
    r = r & MASK;
  endfunction

  function automatic void mset(input int w, input int rw, input int val);
    if (w != 0 && rw != 0) mregs[rw] = val & MASK;
  endfunction

  // Present one instruction, let it be accepted, sample #1 after the edge
  task automatic issue(input int c, input int s, input int d, input int rx,
                       input int ry, input int rw, input int w);
    Ctrl = 4'(c); Sel = 1'(s); DataIn = DW'(d);
    RX = AW'(rx); RY = AW'(ry); RW = AW'(rw); WEN = 1'(w);
    In_valid = 1'b1;
    @(posedge Clk); #1;
    In_valid = 1'b0;
  endtask

  task automatic test_reset;
    if ({Out_valid, Carry, busY, In_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b c=%b y=%h rdy=%b want 0 0 00 1", Out_valid, Carry, busY, In_ready);
    end
    n_vec++;
    issue(12, 1, 8'hAA, 0, 0, 2, 1);
    if ({Out_valid, busY} !== {1'b1, 8'hAA}) begin
      n_err++; $display("FAIL pre_reset_pass: got ov=%b y=%h want 1 aa", Out_valid, busY);
    end
    n_vec++;
    #3 Rst_n = 1'b0;
    #1;
    if ({Out_valid, Carry, busY, In_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got ov=%b c=%b y=%h rdy=%b want 0 0 00 1", Out_valid, Carry, busY, In_ready);
    end
    n_vec++;
    foreach (mregs[i]) mregs[i] = 0;
    @(posedge Clk); #1 Rst_n = 1'b1;
    issue(12, 0, 8'hFF, 2, 0, 0, 0);
    if ({Out_valid, busY} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL reset_regs_cleared: got ov=%b y=%h want 1 00", Out_valid, busY);
    end
    n_vec++;
  endtask

  task automatic test_load_add;
    issue(12, 1, 8'hF0, 0, 0, 1, 1); mset(1, 1, 8'hF0);
    if ({Out_valid, busY} !== {1'b1, 8'hF0}) begin
      n_err++; $display("FAIL load_pass: got ov=%b y=%h want 1 f0", Out_valid, busY);
    end
    n_vec++;
    issue(0, 0, 0, 1, 1, 0, 0);
    if ({Out_valid, Carry, busY} !== {1'b1, 1'b1, 8'hE0}) begin
      n_err++; $display("FAIL add_carry: got ov=%b c=%b y=%h want 1 1 e0", Out_valid, Carry, busY);
    end
    n_vec++;
    @(posedge Clk); #1;
    if ({Out_valid, Carry, busY} !== {1'b0, 1'b1, 8'hE0}) begin
      n_err++; $display("FAIL result_hold: got ov=%b c=%b y=%h want 0 1 e0", Out_valid, Carry, busY);
    end
    n_vec++;
  endtask

  task automatic test_sub_shift;
    issue(12, 1, 7, 0, 0, 2, 1); mset(1, 2, 7);
    issue(12, 1, 1, 0, 0, 3, 1); mset(1, 3, 1);
    issue(1, 1, 8'h05, 0, 2, 0, 0);
    if ({Out_valid, Carry, busY} !== {1'b1, 1'b1, 8'hFE}) begin
      n_err++; $display("FAIL sub_borrow: got ov=%b c=%b y=%h want 1 1 fe", Out_valid, Carry, busY);
    end
    n_vec++;
    issue(8, 1, 8'h81, 0, 3, 0, 0);
    if ({Out_valid, Carry, busY} !== {1'b1, 1'b1, 8'hC0}) begin
      n_err++; $display("FAIL sra_by1: got ov=%b c=%b y=%h want 1 1 c0", Out_valid, Carry, busY);
    end
    n_vec++;
    issue(6, 1, 8'h81, 0, 0, 0, 0);
    if ({Out_valid, Carry, busY} !== {1'b1, 1'b0, 8'h81}) begin
      n_err++; $display("FAIL sll_by0: got ov=%b c=%b y=%h want 1 0 81", Out_valid, Carry, busY);
    end
    n_vec++;
  endtask

  task automatic test_mul;
    issue(12, 1, 8'h10, 0, 0, 4, 1); mset(1, 4, 8'h10);
    issue(11, 1, 8'h12, 0, 4, 0, 0);
    // Hold a different instruction on the inputs while the multiplier is busy
    Ctrl = 4'd12; Sel = 1'b1; DataIn = 8'h77; WEN = 1'b1; RW = 3'd7; In_valid = 1'b1;
    for (int k = 0; k < DW; k++) begin
      if ({In_ready, Out_valid} !== 2'b00) begin
        n_err++; $display("FAIL mul_busy_%0d: got rdy=%b ov=%b want 0 0", k, In_ready, Out_valid);
      end
      n_vec++;
      @(posedge Clk); #1;
    end
    if ({Out_valid, Carry, busY, In_ready} !== {1'b1, 1'b1, 8'h20, 1'b1}) begin
      n_err++;
      $display("FAIL mul_result: got ov=%b c=%b y=%h rdy=%b want 1 1 20 1", Out_valid, Carry, busY, In_ready);
    end
    n_vec++;
    @(posedge Clk); #1;
    In_valid = 1'b0; mset(1, 7, 8'h77);
    if ({Out_valid, busY} !== {1'b1, 8'h77}) begin
      n_err++; $display("FAIL mul_next_accept: got ov=%b y=%h want 1 77", Out_valid, busY);
    end
    n_vec++;
  endtask

  task automatic test_r0_back_to_back;
    issue(12, 1, 8'h55, 0, 0, 0, 1);
    issue(12, 0, 0, 0, 0, 0, 0);
    if ({Out_valid, busY} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL r0_zero: got ov=%b y=%h want 1 00", Out_valid, busY);
    end
    n_vec++;
    issue(12, 1, 8'h33, 0, 0, 5, 1); mset(1, 5, 8'h33);
    if ({Out_valid, busY} !== {1'b1, 8'h33}) begin
      n_err++; $display("FAIL b2b_first: got ov=%b y=%h want 1 33", Out_valid, busY);
    end
    n_vec++;
    issue(0, 0, 0, 5, 5, 0, 0);
    if ({Out_valid, Carry, busY} !== {1'b1, 1'b0, 8'h66}) begin
      n_err++; $display("FAIL b2b_second: got ov=%b c=%b y=%h want 1 0 66", Out_valid, Carry, busY);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid_mul;
    issue(12, 1, 5, 0, 0, 1, 1); mset(1, 1, 5);
    issue(11, 1, 3, 0, 1, 6, 1);
    repeat (3) @(posedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    if ({Out_valid, Carry, busY, In_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL mul_abort_reset: got ov=%b c=%b y=%h rdy=%b want 0 0 00 1", Out_valid, Carry, busY, In_ready);
    end
    n_vec++;
    foreach (mregs[i]) mregs[i] = 0;
    @(posedge Clk); #1 Rst_n = 1'b1;
    for (int k = 0; k < DW + 2; k++) begin
      @(posedge Clk); #1;
      if ({Out_valid, In_ready} !== 2'b01) begin
        n_err++; $display("FAIL mul_abort_quiet_%0d: got ov=%b rdy=%b want 0 1", k, Out_valid, In_ready);
      end
      n_vec++;
    end
    issue(12, 0, 0, 6, 0, 0, 0);
    if ({Out_valid, busY} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL mul_abort_no_wb: got ov=%b y=%h want 1 00", Out_valid, busY);
    end
    n_vec++;
  endtask

  task automatic test_random;
    int op, s, d, rx, ry, rw, w, a, b, r, c;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge Clk); #1; end
      op = $urandom_range(0, 15);
      s  = $urandom_range(0, 1);
      d  = $urandom_range(0, MASK);
      rx = $urandom_range(0, (1 << AW) - 1);
      ry = $urandom_range(0, (1 << AW) - 1);
      rw = $urandom_range(0, (1 << AW) - 1);
      w  = $urandom_range(0, 1);
      a  = (s != 0) ? d : rd(rx);
      b  = rd(ry);
      model(op, a, b, r, c);
      issue(op, s, d, rx, ry, rw, w);
      if (op == 11) begin
        for (int k = 1; k < DW; k++) begin
          if ({In_ready, Out_valid} !== 2'b00) begin
            n_err++; $display("FAIL rand_mul_busy n=%0d k=%0d: got rdy=%b ov=%b want 0 0", n, k, In_ready, Out_valid);
          end
          n_vec++;
          @(posedge Clk); #1;
        end
        if ({In_ready, Out_valid} !== 2'b00) begin
          n_err++; $display("FAIL rand_mul_last_busy n=%0d: got rdy=%b ov=%b want 0 0", n, In_ready, Out_valid);
        end
        n_vec++;
        @(posedge Clk); #1;
      end
      if ({Out_valid, Carry, busY} !== {1'b1, 1'(c), DW'(r)}) begin
        n_err++;
        $display("FAIL rand_op%0d n=%0d a=%h b=%h: got ov=%b c=%b y=%h want 1 %0d %h",
                 op, n, a, b, Out_valid, Carry, busY, c, r);
      end
      n_vec++;
      mset(w, rw, r);
    end
  endtask

  initial begin
    Rst_n = 1'b0; In_valid = 1'b0; WEN = 1'b0; Sel = 1'b0;
    RW = '0; RX = '0; RY = '0; DataIn = '0; Ctrl = '0;
    foreach (mregs[i]) mregs[i] = 0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    test_reset;
    test_load_add;
    test_sub_shift;
    test_mul;
    test_r0_back_to_back;
    test_reset_mid_mul;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
